score_lives_keeper: RTL

Downstream consumer of the hit detector's CoinEn/PoliceEn outputs. Turns hit events into game state: a BCD coin score, remaining lives, a post-crash invulnerability window and a game-over flag. Outputs drive the HEX score display, the lives LEDs and the top-level game FSM (freeze/restart).

---
 rtl/score_lives_keeper.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/score_lives_keeper.sv
// score_lives_keeper: turns coin/police hit levels into game state.
// It keeps a BCD coin score, the remaining lives, a post-crash
// invulnerability window and a game-over flag.
// Optional feature macro: BONUS_LIFE_EN. When it is defined, each
// tens-digit increment of the score grants one life, capped at 3.
module score_lives_keeper #(
   parameter int LIVES_INIT    = 3,
   parameter int INVULN_CYCLES = 50000000,
   parameter int CNT_W         = 26
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       EnterEn,
   input  logic       CoinEn,
   input  logic       PoliceEn,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [1:0] lives,
   output logic       playing,
   output logic       invuln,
   output logic       game_over,
   output logic       coin_pulse
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLAY   = 2'd1;
   localparam logic [1:0] S_INVULN = 2'd2;
   localparam logic [1:0] S_OVER   = 2'd3;

   localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INVULN_CYCLES - 1);

   logic [1:0]       state_reg, state_next;
   logic [3:0]       ones_reg, ones_next;
   logic [3:0]       tens_reg, tens_next;
   logic [1:0]       lives_reg, lives_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             coin_d_reg, police_d_reg;
   logic             coin_pulse_reg, coin_pulse_next;

   logic             coin_ev, police_ev;
   logic             active;
   logic             coin_cnt;
   logic             tens_inc;
   logic             bonus;
   logic [2:0]       lives_sum;

   // The rising edge is seen in the same cycle that the input goes high.
   assign coin_ev   = CoinEn & ~coin_d_reg;
   assign police_ev = PoliceEn & ~police_d_reg;
   assign active    = (state_reg == S_PLAY) || (state_reg == S_INVULN);
   assign coin_cnt  = active & coin_ev;
   // The tens digit advances only on a 9 carry below 99. A saturated
   // score therefore never earns a bonus.
   assign tens_inc  = coin_cnt && (ones_reg == 4'd9) && (tens_reg != 4'd9);

`ifdef BONUS_LIFE_EN
   assign bonus = tens_inc;
`else
   assign bonus = 1'b0;
`endif

   // Bonus and loss are summed before the cap. A hit in the same cycle as
   // a bonus therefore leaves the lives unchanged.
   assign lives_sum = {1'b0, lives_reg} + {2'b00, bonus}
                    - {2'b00, police_ev && (state_reg == S_PLAY)};

   // Registered copies of the hit levels, used for edge detection.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         coin_d_reg   <= 1'b0;
         police_d_reg <= 1'b0;
      end else begin
         coin_d_reg   <= CoinEn;
         police_d_reg <= PoliceEn;
      end
   end

   // Next-state logic for the game state, score, lives and invuln counter.
   always_comb begin
      state_next      = state_reg;
      ones_next       = ones_reg;
      tens_next       = tens_reg;
      lives_next      = lives_reg;
      cnt_next        = cnt_reg;
      coin_pulse_next = coin_cnt;

      // BCD increment with saturation at 99. The pulse still fires at 99.
      if (coin_cnt) begin
         if (ones_reg != 4'd9) begin
            ones_next = ones_reg + 4'd1;
         end else if (tens_reg != 4'd9) begin
            ones_next = 4'd0;
            tens_next = tens_reg + 4'd1;
         end
      end

      case (state_reg)
         S_IDLE, S_OVER: begin
            if (EnterEn) begin
               state_next = S_PLAY;
               ones_next  = 4'd0;
               tens_next  = 4'd0;
               lives_next = LIVES_RST;
               cnt_next   = '0;
            end
         end
         S_PLAY: begin
            if (police_ev) begin
               cnt_next = '0;
               if (lives_sum == 3'd0) begin
                  state_next = S_OVER;
                  lives_next = 2'd0;
               end else begin
                  state_next = S_INVULN;
                  lives_next = (lives_sum > 3'd3) ? 2'd3 : lives_sum[1:0];
               end
            end else begin
               lives_next = (lives_sum > 3'd3) ? 2'd3 : lives_sum[1:0];
            end
         end
         default: begin // S_INVULN: police ignored, coins still count
            lives_next = (lives_sum > 3'd3) ? 2'd3 : lives_sum[1:0];
            if (cnt_reg == CNT_LAST) begin
               state_next = S_PLAY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
      endcase
   end

   // Game state registers with asynchronous return to the IDLE values.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         ones_reg       <= 4'd0;
         tens_reg       <= 4'd0;
         lives_reg      <= LIVES_RST;
         cnt_reg        <= '0;
         coin_pulse_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ones_reg       <= ones_next;
         tens_reg       <= tens_next;
         lives_reg      <= lives_next;
         cnt_reg        <= cnt_next;
         coin_pulse_reg <= coin_pulse_next;
      end
   end

   assign score_ones = ones_reg;
   assign score_tens = tens_reg;
   assign lives      = lives_reg;
   assign playing    = active;
   assign invuln     = (state_reg == S_INVULN);
   assign game_over  = (state_reg == S_OVER);
   assign coin_pulse = coin_pulse_reg;

endmodule
